// File: rtl/fifo_pkg.sv
// Shared constants and pointer type for the single-clock FIFO.
package fifo_pkg;
  localparam int DEFAULT_WIDTH      = 8;
  localparam int DEFAULT_DEPTH      = 32;
  localparam int DEFAULT_ADDR_WIDTH = $clog2(DEFAULT_DEPTH);

  // Pointer carries one extra wrap bit above the memory address bits.
  typedef logic [DEFAULT_ADDR_WIDTH:0] ptr_t;
endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: synchronous write port, registered read port with enable.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]      i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [WIDTH-1:0]      o_rd_data
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  // Storage array is deliberately left without reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read register clears on reset and otherwise holds until the next accepted read.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rd_data <= {WIDTH{1'b0}};
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end else begin
      r_rd_data <= r_rd_data;
    end
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/fifo.sv
// Single-clock FIFO: pointer and flag logic around fifo_mem.
// Optional occupancy output COUNT is enabled by defining FIFO_COUNT_EN.
module fifo
  import fifo_pkg::*;
#(
  parameter  int WIDTH      = DEFAULT_WIDTH,
  parameter  int DEPTH      = DEFAULT_DEPTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [WIDTH-1:0]    DATA_IN,
  input  logic                WR_EN,
  input  logic                R_EN,
  output logic                FULL_FLAG,
  output logic                EMPTY_FLAG,
  output logic [WIDTH-1:0]    DATA_out
`ifdef FIFO_COUNT_EN
  ,
  output logic [ADDR_WIDTH:0] COUNT
`endif
);
  localparam logic [ADDR_WIDTH:0] PTR_ZERO = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0] r_wptr;
  logic [ADDR_WIDTH:0] r_rptr;
  logic [ADDR_WIDTH:0] w_wptr_nxt;
  logic [ADDR_WIDTH:0] w_rptr_nxt;
  logic                w_full;
  logic                w_empty;
  logic                w_wr_acc;
  logic                w_rd_acc;
  logic [WIDTH-1:0]    w_rd_data;

  // Full when addresses match but wrap bits differ; empty when pointers are identical.
  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[ADDR_WIDTH] != r_rptr[ADDR_WIDTH]) &&
                    (r_wptr[ADDR_WIDTH-1:0] == r_rptr[ADDR_WIDTH-1:0]);
  assign w_wr_acc = WR_EN && !w_full;
  assign w_rd_acc = R_EN && !w_empty;

  // Next pointer values; blocked requests leave the pointer unchanged.
  always_comb begin
    w_wptr_nxt = r_wptr;
    w_rptr_nxt = r_rptr;
    if (w_wr_acc) begin
      w_wptr_nxt = r_wptr + PTR_ONE;
    end else begin
      w_wptr_nxt = r_wptr;
    end
    if (w_rd_acc) begin
      w_rptr_nxt = r_rptr + PTR_ONE;
    end else begin
      w_rptr_nxt = r_rptr;
    end
  end

  // Pointer registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_wptr <= PTR_ZERO;
      r_rptr <= PTR_ZERO;
    end else begin
      r_wptr <= w_wptr_nxt;
      r_rptr <= w_rptr_nxt;
    end
  end

  // Reset takes priority over a concurrent write, so the write port is gated too.
  fifo_mem #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .i_clk     (CLK),
    .i_rst_n   (RST),
    .i_wr_en   (w_wr_acc && RST),
    .i_wr_addr (r_wptr[ADDR_WIDTH-1:0]),
    .i_wr_data (DATA_IN),
    .i_rd_en   (w_rd_acc),
    .i_rd_addr (r_rptr[ADDR_WIDTH-1:0]),
    .o_rd_data (w_rd_data)
  );

  assign FULL_FLAG  = w_full;
  assign EMPTY_FLAG = w_empty;
  assign DATA_out   = w_rd_data;

`ifdef FIFO_COUNT_EN
  assign COUNT = r_wptr - r_rptr;
`endif
endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: directed vector table, corner sequences and a queue reference model.
module tb_fifo;
  import fifo_pkg::*;

  localparam int W = DEFAULT_WIDTH;
  localparam int D = DEFAULT_DEPTH;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [W-1:0] DATA_IN = '0;
  logic         WR_EN = 1'b0;
  logic         R_EN = 1'b0;
  logic         FULL_FLAG;
  logic         EMPTY_FLAG;
  logic [W-1:0] DATA_out;
`ifdef FIFO_COUNT_EN
  logic [DEFAULT_ADDR_WIDTH:0] COUNT;
`endif

  int errors = 0;
  int checks = 0;

  logic [W-1:0] model_q[$];
  logic [W-1:0] model_dout = '0;

  always #5 CLK = ~CLK;

  fifo dut (
    .CLK        (CLK),
    .RST        (RST),
    .DATA_IN    (DATA_IN),
    .WR_EN      (WR_EN),
    .R_EN       (R_EN),
    .FULL_FLAG  (FULL_FLAG),
    .EMPTY_FLAG (EMPTY_FLAG),
    .DATA_out   (DATA_out)
`ifdef FIFO_COUNT_EN
    ,
    .COUNT      (COUNT)
`endif
  );

  typedef struct {
    logic         wr;
    logic         rd;
    logic [W-1:0] din;
    logic         e_empty;
    logic         e_full;
    logic [W-1:0] e_dout;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, advance the reference model, sample #1 after the edge.
  task automatic step(input logic rst, input logic wr, input logic rd, input logic [W-1:0] din);
    bit m_full;
    bit m_empty;
    m_full  = (model_q.size() == D);
    m_empty = (model_q.size() == 0);
    RST = rst; WR_EN = wr; R_EN = rd; DATA_IN = din;
    @(posedge CLK);
    if (!rst) begin
      model_q.delete();
      model_dout = '0;
    end else begin
      if (rd && !m_empty) model_dout = model_q.pop_front();
      if (wr && !m_full) model_q.push_back(din);
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_empty"}, EMPTY_FLAG, (model_q.size() == 0));
    chk({tag, "_full"}, FULL_FLAG, (model_q.size() == D));
    chk({tag, "_dout"}, DATA_out, model_dout);
`ifdef FIFO_COUNT_EN
    chk({tag, "_count"}, COUNT, model_q.size());
`endif
  endtask

  initial begin
    logic [W-1:0] drop_val;
    bit           found;

    vecs[0] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[2] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 8'h00};
    vecs[4] = '{1'b1, 1'b0, 8'h81, 1'b0, 1'b0, 8'h00};
    vecs[5] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'hFF};
    vecs[6] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h81};
    vecs[7] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h81};

    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'h3C);
    chk("rst_empty", EMPTY_FLAG, 1'b1);
    chk("rst_full", FULL_FLAG, 1'b0);
    chk("rst_dout", DATA_out, 8'h00);

    for (int i = 0; i < 8; i++) begin
      step(1'b1, vecs[i].wr, vecs[i].rd, vecs[i].din);
      chk($sformatf("vec%0d_empty", i), EMPTY_FLAG, vecs[i].e_empty);
      chk($sformatf("vec%0d_full", i), FULL_FLAG, vecs[i].e_full);
      chk($sformatf("vec%0d_dout", i), DATA_out, vecs[i].e_dout);
    end

    for (int i = 0; i < D; i++) step(1'b1, 1'b1, 1'b0, W'($urandom));
    chk("fill_full", FULL_FLAG, 1'b1);
    chk("fill_empty", EMPTY_FLAG, 1'b0);
`ifdef FIFO_COUNT_EN
    chk("fill_count", COUNT, D);
`endif

    // Pick a value absent from the stored words so a leak of the dropped write is visible.
    drop_val = '0;
    for (int tries = 0; tries < 256; tries++) begin
      found = 1'b0;
      foreach (model_q[k]) if (model_q[k] == W'(tries)) found = 1'b1;
      if (!found) begin
        drop_val = W'(tries);
        break;
      end
    end
    step(1'b1, 1'b1, 1'b0, drop_val);
    check_model("overflow");

    for (int i = 0; i < D; i++) begin
      step(1'b1, 1'b0, 1'b1, 8'h00);
      check_model($sformatf("drain%0d", i));
      chk($sformatf("drain%0d_nodrop", i), (DATA_out == drop_val), 1'b0);
    end
    chk("drained_empty", EMPTY_FLAG, 1'b1);
    chk("drained_full", FULL_FLAG, 1'b0);

    step(1'b1, 1'b0, 1'b1, 8'h00);
    check_model("underflow");

    for (int i = 0; i < D; i++) step(1'b1, 1'b1, 1'b0, W'($urandom));
    chk("refill_full", FULL_FLAG, 1'b1);
    check_model("refill");

    for (int i = 0; i < D / 2; i++) begin
      step(1'b1, 1'b0, 1'b1, 8'h00);
      check_model($sformatf("half%0d", i));
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b1, W'($urandom));
      check_model($sformatf("simul%0d", i));
      chk($sformatf("simul%0d_flags", i), {FULL_FLAG, EMPTY_FLAG}, 2'b00);
`ifdef FIFO_COUNT_EN
      chk($sformatf("simul%0d_occ", i), COUNT, D / 2);
`endif
    end

    step(1'b0, 1'b1, 1'b1, 8'h5A);
    chk("midrst_empty", EMPTY_FLAG, 1'b1);
    chk("midrst_full", FULL_FLAG, 1'b0);
    chk("midrst_dout", DATA_out, 8'h00);
    step(1'b1, 1'b0, 1'b1, 8'h00);
    check_model("postrst_read");

    // Random traffic in write-heavy, read-heavy and balanced phases to hit both boundaries.
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 120; i++) begin
        int  wp;
        logic wr;
        logic rd;
        wp = (ph == 0) ? 80 : ((ph == 1) ? 20 : 50);
        wr = ($urandom_range(99) < wp);
        rd = ($urandom_range(99) < (100 - wp));
        step(1'b1, wr, rd, W'($urandom));
        check_model($sformatf("rand%0d_%0d", ph, i));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
